// File: rtl/s526_bist_driver_pkg.sv
// Shared types and constants for the s526 BIST driver: state encoding, polynomial taps, widths.
package s526_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    DONE
  } bist_state_e;

  localparam int PAT_W  = 3;
  localparam int RESP_W = 6;
  localparam int SIG_W  = 16;

  // Taps at bits 15,13,12,10 shared by the pattern LFSR and the MISR.
  localparam logic [SIG_W-1:0] TAP_MASK = 16'hB400;

  // An all-zero LFSR never leaves zero, so a zero seed is swapped for 1.
  function automatic logic [SIG_W-1:0] seed_fix(input logic [SIG_W-1:0] s);
    return (s == '0) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/s526_bist_driver_if.sv
// Harness-side bus of the s526 BIST driver; PASS exists only with S526_BIST_CMP_EN defined.
interface s526_bist_if;

  logic                                 START;
  logic [s526_bist_pkg::PAT_W-1:0]      PAT;
  logic [s526_bist_pkg::RESP_W-1:0]     RESP;
  logic                                 BUSY;
  logic                                 DONE;
  logic [s526_bist_pkg::SIG_W-1:0]      SIG;
`ifdef S526_BIST_CMP_EN
  logic                                 PASS;

  modport master (input START, RESP, output PAT, BUSY, DONE, SIG, PASS);
  modport slave  (output START, RESP, input PAT, BUSY, DONE, SIG, PASS);
`else
  modport master (input START, RESP, output PAT, BUSY, DONE, SIG);
  modport slave  (output START, RESP, input PAT, BUSY, DONE, SIG);
`endif

endinterface

// File: rtl/s526_bist_driver_lfsr16.sv
// 16-bit shift register with seed load; mode selects plain LFSR or MISR (data folded in).
module bist_lfsr16
  import s526_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             misr_mode_i,
  input  logic [SIG_W-1:0] seed_i,
  input  logic [SIG_W-1:0] data_i,
  output logic [SIG_W-1:0] q_o,
  output logic [SIG_W-1:0] d_o
);

  logic [SIG_W-1:0] val_q, val_d, step;

  always_comb begin
    step = {val_q[SIG_W-2:0], ^(val_q & TAP_MASK)};
    if (misr_mode_i) step = step ^ data_i;
    val_d = val_q;
    if (load_i)    val_d = seed_i;
    else if (en_i) val_d = step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= RST_VAL;
    else     val_q <= val_d;
  end

  assign q_o = val_q;
  assign d_o = val_d;

endmodule

// File: rtl/s526_bist_driver.sv
// s526 BIST driver: LFSR patterns out, MISR signature of responses in.
// Optional golden compare with PASS output when S526_BIST_CMP_EN is defined.
//
// state | meaning
// IDLE  | after reset, waiting for START
// INIT  | PAT=001 holds the s526 synchronous clear for INIT_CYC cycles
// RUN   | N_PAT pseudo-random patterns applied
// DRAIN | PAT=0 for RESP_LAT cycles while last responses fold in
// DONE  | signature stable, waiting for START
module s526_bist_driver
  import s526_bist_pkg::*;
#(
  parameter int unsigned      N_PAT     = 256,
  parameter int unsigned      INIT_CYC  = 2,
  parameter int unsigned      RESP_LAT  = 1,
  parameter logic [SIG_W-1:0] LFSR_SEED = 16'hACE1,
  parameter logic [SIG_W-1:0] MISR_SEED = 16'h0000
`ifdef S526_BIST_CMP_EN
  , parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
`endif
) (
  input logic         CK,
  input logic         RST,
  s526_bist_if.master bus
);

  localparam logic [15:0]      INIT_LD  = 16'(INIT_CYC - 1);
  localparam logic [15:0]      RUN_LD   = 16'(N_PAT - 1);
  localparam logic [15:0]      DRAIN_LD = 16'(RESP_LAT - 1);
  localparam logic [SIG_W-1:0] LFSR_LD  = seed_fix(LFSR_SEED);

  bist_state_e         state_q;
  logic [15:0]         cnt_q;
  logic [PAT_W-1:0]    pat_q;
  logic                busy_q, done_q;
  logic [RESP_LAT-1:0] vld_q;
  logic                start_acc, cnt_zero, unused_bits;
  logic [SIG_W-1:0]    lfsr_q, lfsr_d, misr_q, misr_d;

  assign start_acc = bus.START && (state_q == IDLE || state_q == DONE);
  assign cnt_zero  = (cnt_q == '0);

  bist_lfsr16 #(.RST_VAL(LFSR_LD)) u_lfsr (
    .clk(CK), .rst(RST), .load_i(start_acc), .en_i(state_q == RUN),
    .misr_mode_i(1'b0), .seed_i(LFSR_LD), .data_i('0),
    .q_o(lfsr_q), .d_o(lfsr_d)
  );

  // MISR advances only when the delayed RUN marker says a real response is present.
  bist_lfsr16 #(.RST_VAL(MISR_SEED)) u_misr (
    .clk(CK), .rst(RST), .load_i(start_acc), .en_i(vld_q[RESP_LAT-1]),
    .misr_mode_i(1'b1), .seed_i(MISR_SEED), .data_i({{(SIG_W-RESP_W){1'b0}}, bus.RESP}),
    .q_o(misr_q), .d_o(misr_d)
  );

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      vld_q <= RESP_LAT'({vld_q, state_q == RUN});
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.START) begin
            state_q <= INIT;
            cnt_q   <= INIT_LD;
            pat_q   <= 3'b001;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        INIT: begin
          if (cnt_zero) begin
            state_q <= RUN;
            cnt_q   <= RUN_LD;
            pat_q   <= lfsr_q[PAT_W-1:0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RUN: begin
          if (cnt_zero) begin
            state_q <= DRAIN;
            cnt_q   <= DRAIN_LD;
            pat_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            pat_q <= lfsr_d[PAT_W-1:0];
          end
        end
        DRAIN: begin
          if (cnt_zero) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.PAT  = pat_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.SIG  = misr_q;

`ifdef S526_BIST_CMP_EN
  logic pass_q;

  // Compare against the post-update MISR value, since the final fold lands on the DONE edge.
  always_ff @(posedge CK or posedge RST) begin
    if (RST)                             pass_q <= 1'b0;
    else if (start_acc)                  pass_q <= 1'b0;
    else if (state_q == DRAIN && cnt_zero) pass_q <= (misr_d == GOLDEN_SIG);
  end

  assign bus.PASS    = pass_q;
  assign unused_bits = ^{lfsr_q[SIG_W-1:PAT_W], lfsr_d[SIG_W-1:PAT_W]};
`else
  assign unused_bits = ^{lfsr_q[SIG_W-1:PAT_W], lfsr_d[SIG_W-1:PAT_W], misr_d};
`endif

endmodule

// File: tb/tb_s526_bist_driver.sv
// Bench for s526_bist_driver: five parameterisations share START/RESP/RST and are checked
// every cycle against a session-index reference model; PASS checked when S526_BIST_CMP_EN is set.
module tb_s526_bist_driver;

  localparam int N_INST = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] resp;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cfg_np(input int g);
    case (g)
      0: return 3;
      1: return 1;
      2, 4: return 2;
      default: return 17;
    endcase
  endfunction

  function automatic int cfg_ic(input int g);
    case (g)
      1: return 1;
      3: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_lat(input int g);
    return (g == 3) ? 4 : 1;
  endfunction

  function automatic logic [15:0] cfg_lseed(input int g);
    return (g == 3) ? 16'h0000 : 16'hACE1;
  endfunction

  function automatic logic [15:0] cfg_mseed(input int g);
    return (g == 3) ? 16'h1234 : 16'h0000;
  endfunction

  // Shift-left register rule with taps 15,13,12,10.
  function automatic logic [15:0] sr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] r);
    return sr_step(m) ^ {10'b0, r};
  endfunction

  function automatic logic [2:0] pat_at(input logic [15:0] seed, input int k);
    logic [15:0] v;
    v = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int i = 0; i < k; i++) v = sr_step(v);
    return v[2:0];
  endfunction

  // Expected PAT from position within the busy window of a session.
  function automatic logic [2:0] exp_pat(input bit busy, input int idx, input int ic,
                                         input int np, input logic [15:0] seed);
    if (!busy)        return 3'b000;
    if (idx < ic)     return 3'b001;
    if (idx < ic + np) return pat_at(seed, idx - ic);
    return 3'b000;
  endfunction

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    localparam int          NP  = cfg_np(g);
    localparam int          IC  = cfg_ic(g);
    localparam int          LAT = cfg_lat(g);
    localparam int          TOT = IC + NP + LAT;
    localparam logic [15:0] LS  = cfg_lseed(g);
    localparam logic [15:0] MS  = cfg_mseed(g);

    s526_bist_if u_if ();
    assign u_if.START = start;
    assign u_if.RESP  = resp;

`ifdef S526_BIST_CMP_EN
    localparam logic [15:0] GS = (g == 2) ? 16'h0003 : ((g == 4) ? 16'h0004 : 16'h0000);
    s526_bist_driver #(.N_PAT(NP), .INIT_CYC(IC), .RESP_LAT(LAT), .LFSR_SEED(LS),
                       .MISR_SEED(MS), .GOLDEN_SIG(GS))
      u_dut (.CK(clk), .RST(rst), .bus(u_if.master));
`else
    s526_bist_driver #(.N_PAT(NP), .INIT_CYC(IC), .RESP_LAT(LAT), .LFSR_SEED(LS),
                       .MISR_SEED(MS))
      u_dut (.CK(clk), .RST(rst), .bus(u_if.master));
`endif

    int          m_idx  = 0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [15:0] m_sig  = MS;
`ifdef S526_BIST_CMP_EN
    bit          m_pass = 1'b0;
`endif

    // Responses in busy positions IC+LAT .. TOT-1 are the ones folded into the signature.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
        m_idx  <= 0;
        m_sig  <= MS;
`ifdef S526_BIST_CMP_EN
        m_pass <= 1'b0;
`endif
      end else if (m_busy) begin
        if (m_idx >= IC + LAT) m_sig <= misr_step(m_sig, resp);
        if (m_idx == TOT - 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
`ifdef S526_BIST_CMP_EN
          m_pass <= (misr_step(m_sig, resp) == GS);
`endif
        end else begin
          m_idx <= m_idx + 1;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_done <= 1'b0;
        m_idx  <= 0;
        m_sig  <= MS;
`ifdef S526_BIST_CMP_EN
        m_pass <= 1'b0;
`endif
      end
    end

    always @(negedge clk) begin
      chk_val($sformatf("i%0d PAT", g),  32'(u_if.PAT),  32'(exp_pat(m_busy, m_idx, IC, NP, LS)));
      chk_val($sformatf("i%0d BUSY", g), 32'(u_if.BUSY), 32'(m_busy));
      chk_val($sformatf("i%0d DONE", g), 32'(u_if.DONE), 32'(m_done));
      chk_val($sformatf("i%0d SIG", g),  32'(u_if.SIG),  32'(m_sig));
`ifdef S526_BIST_CMP_EN
      chk_val($sformatf("i%0d PASS", g), 32'(u_if.PASS), 32'(m_pass));
`endif
    end

    // Reset must act without waiting for a clock edge.
    always @(posedge rst) begin
      #1;
      chk_val($sformatf("i%0d async rst PAT", g),  32'(u_if.PAT),  32'd0);
      chk_val($sformatf("i%0d async rst BUSY", g), 32'(u_if.BUSY), 32'd0);
      chk_val($sformatf("i%0d async rst DONE", g), 32'(u_if.DONE), 32'd0);
      chk_val($sformatf("i%0d async rst SIG", g),  32'(u_if.SIG),  32'(MS));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic check_all_done(input string tag);
    chk_val({tag, " i0 DONE"}, 32'(g_dut[0].u_if.DONE), 32'd1);
    chk_val({tag, " i1 DONE"}, 32'(g_dut[1].u_if.DONE), 32'd1);
    chk_val({tag, " i2 DONE"}, 32'(g_dut[2].u_if.DONE), 32'd1);
    chk_val({tag, " i3 DONE"}, 32'(g_dut[3].u_if.DONE), 32'd1);
    chk_val({tag, " i4 DONE"}, 32'(g_dut[4].u_if.DONE), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    resp  = 6'h00;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Constant RESP=1, run twice; a START pulse lands mid-session for the longer configs.
    resp = 6'h01;
    for (int s = 0; s < 2; s++) begin
      start = 1'b1; tick(1); start = 1'b0;
      tick(3);
      start = 1'b1; tick(1); start = 1'b0;
      tick(40);
      check_all_done("resp1");
      chk_val("resp1 np1 SIG", 32'(g_dut[1].u_if.SIG), 32'h0001);
      chk_val("resp1 np2 SIG", 32'(g_dut[2].u_if.SIG), 32'h0003);
      chk_val("resp1 np2 g4 SIG", 32'(g_dut[4].u_if.SIG), 32'h0003);
`ifdef S526_BIST_CMP_EN
      chk_val("golden 3 PASS", 32'(g_dut[2].u_if.PASS), 32'd1);
      chk_val("golden 4 PASS", 32'(g_dut[4].u_if.PASS), 32'd0);
`endif
    end

    resp = 6'h00;
    start = 1'b1; tick(1); start = 1'b0;
    tick(40);
    check_all_done("resp0");
    chk_val("resp0 i0 SIG", 32'(g_dut[0].u_if.SIG), 32'h0000);
    chk_val("resp0 i1 SIG", 32'(g_dut[1].u_if.SIG), 32'h0000);
    chk_val("resp0 i2 SIG", 32'(g_dut[2].u_if.SIG), 32'h0000);

    for (int i = 0; i < 500; i++) begin
      resp  = 6'($urandom);
      start = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick(2);

    // START held high: back-to-back sessions, one restart per visit to DONE.
    resp  = 6'h2B;
    start = 1'b1;
    tick(60);
    start = 1'b0;
    tick(40);
    check_all_done("held");

    // Reset in the middle of a session, then a clean session with random responses.
    start = 1'b1; tick(1); start = 1'b0;
    tick(5);
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(1);
    for (int i = 0; i < 40; i++) begin
      resp  = 6'($urandom);
      start = (i == 0);
      tick(1);
    end
    check_all_done("post rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
